// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Brief    : RV32I instruction fetch stage. Sequences the PC, issues
//             in-order requests to instruction memory under a credit limit,
//             buffers returned words in a small FIFO and hands them to decode
//             with opcode/funct3/funct7 pre-split. PC redirects flush the
//             buffer and drain any responses still in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);

    // Counter width holds 0..FIFO_DEPTH; pointer width indexes the buffer.
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] C_LAST  = PW'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_fetch_pc_next;
    logic [XLEN-1:0] w_redirect_target;

    // PC of the next response expected to be buffered. Responses come back
    // in request order and stale ones are drained before new ones arrive,
    // so a single running counter is enough to tag each pushed word.
    logic [XLEN-1:0] r_resp_pc;

    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   w_outstanding_next;
    logic [CW:0]     w_credit_used;

    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_word_mem [FIFO_DEPTH];
    logic [XLEN-1:0] r_pc_mem   [FIFO_DEPTH];

    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_unused_low_bits;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + PW'(1);
    endfunction

    // The two low redirect bits are forced to zero; keep them referenced.
    assign w_unused_low_bits = ^redirect_pc[1:0];
    assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit is taken from registered occupancy only, so a pop this cycle
    // frees a slot for the request issued next cycle, never this one.
    assign w_credit_used  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !reset && (r_state == ST_FETCH)
                            && (w_credit_used < {1'b0, C_DEPTH});
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A redirect discards whatever response or handshake coincides with it.
    assign w_push     = imem_resp_valid && (r_state == ST_FETCH) && !redirect_valid;
    assign inst_valid = !reset && (r_count != '0);
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;

    // Decode-side view of the buffer head.
    assign inst    = r_word_mem[r_rd_ptr];
    assign inst_pc = r_pc_mem[r_rd_ptr];
    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign funct7  = inst[31:25];

    // Outstanding requests: +1 on accept, -1 on any response (kept or dropped).
    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_req_fire && !imem_resp_valid) begin
            w_outstanding_next = r_outstanding + CW'(1);
        end else if (!w_req_fire && imem_resp_valid) begin
            w_outstanding_next = r_outstanding - CW'(1);
        end
    end

    // Buffer occupancy: flush on redirect, otherwise push/pop bookkeeping.
    always_comb begin
        w_count_next = r_count;
        if (redirect_valid) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Next PC and FETCH/DRAIN transitions; a redirect overrides the +4 step.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        if (w_req_fire) begin
            w_fetch_pc_next = r_fetch_pc + XLEN'(4);
        end
        if (redirect_valid) begin
            w_fetch_pc_next = w_redirect_target;
        end
        case (r_state)
            ST_FETCH: begin
                if (redirect_valid && (w_outstanding_next != '0)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_outstanding_next == '0) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // Control state register: FSM, PCs, counters and buffer pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_FETCH;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_count       <= w_count_next;
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_resp_pc <= w_redirect_target;
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
            end else begin
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                    r_wr_ptr  <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
            end
        end
    end

    // Buffer storage: data only, validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_word_mem[r_wr_ptr] <= imem_resp_data;
            r_pc_mem[r_wr_ptr]   <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch
//  Brief    : Self-checking bench for inst_fetch. A queue-based memory model
//             answers requests in order after a programmable latency; a
//             stream model predicts the PC sequence decode must observe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int          XLEN       = 32;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC   = 32'h0;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    inst_fetch #(
        .XLEN       (XLEN),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       pend[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    int          cycle;
    int          mem_lat;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic        p_held;
    logic [31:0] p_addr;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_inst_valid;
    logic [31:0] s_inst_pc;
    logic [6:0]  s_opcode;
    logic        s_resp_valid;

    // Content of instruction memory; address 0 holds an R-type ADD.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00B50533;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
    endfunction

    // Occupancy must never exceed the buffer depth.
    always @(negedge clk) begin
        if (!reset) begin
            assert (int'(dut.r_count) <= FIFO_DEPTH && int'(dut.r_outstanding) <= FIFO_DEPTH)
                else $error("occupancy overflow");
        end
    end

    // One clock cycle: drive memory, sample, update the stream model, advance.
    task automatic tick();
        logic [31:0] w;
        if (!reset && pend.size() > 0 && pend[0].due <= cycle) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_opcode     = opcode;
        s_resp_valid = imem_resp_valid;
        if (reset) begin
            pend.delete();
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
            p_held  = 1'b0;
        end else begin
            if (p_held) begin
                vectors++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== p_addr) begin
                    miscompares++;
                    $display("FAIL req_hold: valid=%b addr=%h, required valid=1 addr=%h",
                             imem_req_valid, imem_req_addr, p_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                vectors++;
                if (imem_req_addr !== exp_req) begin
                    miscompares++;
                    $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_req);
                end
                pend.push_back('{addr: imem_req_addr, due: cycle + mem_lat});
                req_log.push_back(imem_req_addr);
                exp_req = exp_req + 32'd4;
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                w = mem_word(exp_pc);
                vectors++;
                if (inst_pc !== exp_pc || inst !== w || opcode !== w[6:0]
                    || funct3 !== w[14:12] || funct7 !== w[31:25]) begin
                    miscompares++;
                    $display("FAIL inst_stream: pc=%h inst=%h op=%h f3=%h f7=%h, required pc=%h inst=%h",
                             inst_pc, inst, opcode, funct3, funct7, exp_pc, w);
                end
                pop_log.push_back(inst_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (imem_resp_valid) void'(pend.pop_front());
            if (redirect_valid) begin
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
            end
            p_held = imem_req_valid && !imem_req_ready && !redirect_valid;
            p_addr = imem_req_addr;
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; reset = 1'b1;
        tick();
        vectors++;
        if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cycle: req_valid=%b inst_valid=%b, required 0 0", s_req_valid, s_inst_valid);
        end
        reset = 1'b0;
        clear_logs();
        tick();
        vectors++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC || s_inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_req: valid=%b addr=%h inst_valid=%b, required 1 %h 0",
                     s_req_valid, s_req_addr, s_inst_valid, RESET_PC);
        end
    endtask

    task automatic test_straight();
        logic [6:0] op0;
        op0 = 7'h0;
        mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_inst_valid && s_inst_pc == 32'h0) op0 = s_opcode;
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (req_log.size() <= i || pop_log.size() <= i
                || req_log[i] !== 32'(i * 4) || pop_log[i] !== 32'(i * 4)) begin
                miscompares++;
                $display("FAIL straight_order[%0d]: req=%0d pops=%0d entries, required addr/pc %h",
                         i, req_log.size(), pop_log.size(), 32'(i * 4));
            end
        end
        vectors++;
        if (op0 !== 7'h33) begin
            miscompares++;
            $display("FAIL straight_opcode: got %h, required 33", op0);
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (req_log.size() != 2 || s_req_valid !== 1'b0 || s_inst_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_stall: reqs=%0d req_valid=%b inst_valid=%b, required 2 0 1",
                     req_log.size(), s_req_valid, s_inst_valid);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (pop_log.size() <= i || pop_log[i] !== 32'(i * 4)) begin
                miscompares++;
                $display("FAIL backpressure_release[%0d]: pops=%0d, required pc %h",
                         i, pop_log.size(), 32'(i * 4));
            end
        end
    endtask

    task automatic test_redirect_drain();
        int found;
        mem_lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0 || s_resp_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL drain_cycle[%0d]: req_valid=%b inst_valid=%b resp=%b, required 0 0 1",
                         i, s_req_valid, s_inst_valid, s_resp_valid);
            end
        end
        tick();
        vectors++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL drain_exit_req: valid=%b addr=%h, required 1 00000100", s_req_valid, s_req_addr);
        end
        found = 0;
        for (int i = 0; i < 20 && pop_log.size() == 0; i++) tick();
        vectors++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL drain_first_pc: pops=%0d, required first pc 00000100", pop_log.size());
        end
    endtask

    task automatic test_wrap();
        mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_req: reqs=%0d, required FFFFFFFC then 00000000", req_log.size());
        end
        vectors++;
        if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_pc: pops=%0d, required FFFFFFFC then 00000000", pop_log.size());
        end
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (req_log.size() < 1 || pop_log.size() < 1
            || req_log[0] !== 32'h100 || pop_log[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL misaligned_redirect: reqs=%0d pops=%0d, required first addr/pc 00000100",
                     req_log.size(), pop_log.size());
        end
    endtask

    task automatic test_same_cycle();
        mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if (s_inst_valid !== 1'b1 || s_resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_setup: inst_valid=%b resp=%b, required 1 1", s_inst_valid, s_resp_valid);
        end
        clear_logs();
        tick();
        vectors++;
        if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL same_cycle_flush: inst_valid=%b req_valid=%b addr=%h, required 0 1 00000200",
                     s_inst_valid, s_req_valid, s_req_addr);
        end
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h200) begin
            miscompares++;
            $display("FAIL same_cycle_resume: pops=%0d, required first pc 00000200", pop_log.size());
        end
    endtask

    task automatic test_reset_midstream();
        mem_lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (req_log.size() != 2 || s_resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midstream_setup: reqs=%0d resp=%b, required 2 1", req_log.size(), s_resp_valid);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midstream_reset_cycle: inst_valid=%b req_valid=%b, required 0 0",
                     s_inst_valid, s_req_valid);
        end
        reset = 1'b0; inst_ready = 1'b1;
        clear_logs();
        tick();
        vectors++;
        if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL midstream_restart: inst_valid=%b req_valid=%b addr=%h, required 0 1 %h",
                     s_inst_valid, s_req_valid, s_req_addr, RESET_PC);
        end
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (pop_log.size() == 0 || pop_log[0] !== RESET_PC) begin
            miscompares++;
            $display("FAIL midstream_first_pc: pops=%0d, required first pc %h", pop_log.size(), RESET_PC);
        end
    endtask

    task automatic test_random();
        int total_pops;
        total_pops = 0;
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            mem_lat = int'($urandom_range(1, 4));
            for (int i = 0; i < 300; i++) begin
                imem_req_ready = ($urandom_range(0, 9) < 7);
                inst_ready     = ($urandom_range(0, 9) < 6);
                redirect_valid = ($urandom_range(0, 19) == 0);
                redirect_pc    = $urandom;
                reset          = ($urandom_range(0, 199) == 0);
                tick();
                total_pops += pop_log.size();
                clear_logs();
            end
        end
        reset = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        total_pops += pop_log.size();
        vectors++;
        if (total_pops < 100) begin
            miscompares++;
            $display("FAIL random_progress: %0d instructions delivered, required at least 100", total_pops);
        end
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        cycle           = 0;
        mem_lat         = 1;
        exp_pc          = RESET_PC;
        exp_req         = RESET_PC;
        p_held          = 1'b0;
        p_addr          = 32'h0;
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        @(negedge clk);
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect_drain();
        test_wrap();
        test_same_cycle();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
